// File: rtl/boa_mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, LOCK0, LOCK1)
//   port_idx_t  : one-bit requester index (PORT0 = fetch, PORT1 = data)
package boa_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_t;

   typedef logic port_idx_t;

   localparam port_idx_t PORT0 = 1'b0;
   localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/boa_mem_bus.sv
// Simple single-cycle-handshake memory bus.
//   re, we      : read / write strobes from the requester
//   addr, wdata : address and write data, held until ready
//   rdata       : read data from the memory
//   ready       : transaction completes in the cycle this is high
// Modports:
//   CPU : requester view (drives strobes, receives rdata/ready)
//   MEM : memory view (receives strobes, drives rdata/ready)
interface boa_mem_bus #(
   parameter int alen = 32,
   parameter int dlen = 32
);
   logic            re;
   logic            we;
   logic [alen-1:0] addr;
   logic [dlen-1:0] wdata;
   logic [dlen-1:0] rdata;
   logic            ready;

   modport CPU (output re, output we, output addr, output wdata,
                input rdata, input ready);
   modport MEM (input re, input we, input addr, input wdata,
                output rdata, output ready);
endinterface

// File: rtl/boa_rr_pick.sv
// Two-way winner selection.
//   req  : request bits, req[n] = port n requesting
//   last : port that completed the most recent transaction
//   rr   : 1 = round-robin tie break, 0 = port 0 always wins ties
//   win  : selected port (port 0 when nobody requests; unused then)
module boa_rr_pick
   import boa_mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_idx_t  last,
   input  logic       rr,
   output port_idx_t  win
);

   always_comb begin
      win = PORT0;
      if (req == 2'b10) begin
         win = PORT1;
      end else if (req == 2'b11 && rr) begin
         // Tie: hand the grant to the port that was not served last.
         win = ~last;
      end
   end

endmodule

// File: rtl/boa_mem_arbiter.sv
// Arbitrates two requesters (p0 = instruction fetch, p1 = data) onto one
// shared memory bus. In IDLE the winner is forwarded combinationally with no
// added latency; if the memory stalls, the bus is locked to that winner until
// ready.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   p0/p1 : requester buses (MEM view)
//   mem   : shared memory bus (CPU view)
//   owner : locked port, meaningful only while busy
//   busy  : high while a stalled transaction holds the bus
module boa_mem_arbiter
   import boa_mem_arb_pkg::*;
#(
   parameter int alen = 32,
   parameter int dlen = 32,
   parameter int rr   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   boa_mem_bus.MEM    p0,
   boa_mem_bus.MEM    p1,
   boa_mem_bus.CPU    mem,
   output logic       owner,
   output logic       busy
);

   localparam logic rr_en = (rr != 0);

   arb_state_t      state;
   port_idx_t       last;
   port_idx_t       win;
   port_idx_t       sel;
   logic [1:0]      req;
   logic            fwd;
   logic            sel_re;
   logic            sel_we;
   logic [alen-1:0] sel_addr;
   logic [dlen-1:0] sel_wdata;

   // A port requests while either strobe is high; the access type is not
   // interpreted, so re and we together are simply passed through.
   assign req = {p1.re | p1.we, p0.re | p0.we};

   boa_rr_pick u_pick (
      .req  (req),
      .last (last),
      .rr   (rr_en),
      .win  (win)
   );

   // Select the port driving the bus and whether anything is forwarded.
   // A locked owner stays forwarded even if it drops its strobes.
   always_comb begin
      sel = win;
      fwd = 1'b0;
      case (state)
         IDLE: begin
            sel = win;
            fwd = |req;
         end
         LOCK0: begin
            sel = PORT0;
            fwd = 1'b1;
         end
         LOCK1: begin
            sel = PORT1;
            fwd = 1'b1;
         end
         default: begin
            sel = win;
            fwd = 1'b0;
         end
      endcase
      // Reset silences the bus immediately, independent of the clock.
      if (!rst_n) begin
         fwd = 1'b0;
      end
   end

   // Plain 2:1 data-path mux.
   assign sel_re    = (sel == PORT1) ? p1.re    : p0.re;
   assign sel_we    = (sel == PORT1) ? p1.we    : p0.we;
   assign sel_addr  = (sel == PORT1) ? p1.addr  : p0.addr;
   assign sel_wdata = (sel == PORT1) ? p1.wdata : p0.wdata;

   assign mem.re    = fwd & sel_re;
   assign mem.we    = fwd & sel_we;
   assign mem.addr  = fwd ? sel_addr  : '0;
   assign mem.wdata = fwd ? sel_wdata : '0;

   assign p0.ready  = fwd & (sel == PORT0) & mem.ready;
   assign p1.ready  = fwd & (sel == PORT1) & mem.ready;
   assign p0.rdata  = mem.rdata;
   assign p1.rdata  = mem.rdata;

   assign busy  = (state == LOCK0) || (state == LOCK1);
   assign owner = (state == LOCK1);

   // Only the FSM state and the last-served pointer are stored. Last-served
   // resets to port 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         last  <= PORT1;
      end else begin
         case (state)
            IDLE: begin
               if (fwd) begin
                  if (mem.ready) begin
                     last <= win;
                  end else begin
                     state <= (win == PORT1) ? LOCK1 : LOCK0;
                  end
               end
            end
            LOCK0: begin
               if (mem.ready) begin
                  state <= IDLE;
                  last  <= PORT0;
               end
            end
            LOCK1: begin
               if (mem.ready) begin
                  state <= IDLE;
                  last  <= PORT1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
